seg_scan: RTL

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan_pkg.sv | 41 ++++
 rtl/seg_scan_decode.sv | 27 ++
 rtl/seg_scan.sv | 89 ++++++++
 3 files changed

// File: rtl/seg_scan_pkg.sv
// Shared constants for the 4-digit multiplexed stopwatch display.
// Holds the glyphs, the adjust-field codes and the scan-slot-to-digit mapping.
package seg_scan_pkg;

  typedef logic [4:0] digit_t;

  // Glyphs are {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] GLYPH_0     = 7'b1000000;
  localparam logic [6:0] GLYPH_1     = 7'b1111001;
  localparam logic [6:0] GLYPH_2     = 7'b0100100;
  localparam logic [6:0] GLYPH_3     = 7'b0110000;
  localparam logic [6:0] GLYPH_4     = 7'b0011001;
  localparam logic [6:0] GLYPH_5     = 7'b0010010;
  localparam logic [6:0] GLYPH_6     = 7'b0000010;
  localparam logic [6:0] GLYPH_7     = 7'b1111000;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0010000;
  localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  localparam logic [3:0] AN_BLANK = 4'b1111;

  localparam logic [2:0] ADJ_NONE = 3'd0;
  localparam logic [2:0] ADJ_SEC  = 3'd1;
  localparam logic [2:0] ADJ_MIN  = 3'd2;

  localparam logic [1:0] IDX_SEC_R = 2'd0;
  localparam logic [1:0] IDX_SEC_L = 2'd1;
  localparam logic [1:0] IDX_MIN_R = 2'd2;
  localparam logic [1:0] IDX_MIN_L = 2'd3;

  // Seconds occupy slots 0-1 and minutes slots 2-3, so idx[1] picks the pair.
  function automatic logic in_adj_pair(input logic [2:0] sel, input logic [1:0] idx);
    case (sel)
      ADJ_SEC: return !idx[1];
      ADJ_MIN: return idx[1];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_decode.sv
// Combinational 5-bit value to active-low seven-segment glyph.
// Anything outside 0-9 renders as a dash.
module seg7_decode
  import seg_scan_pkg::*;
(
  input  logic [4:0] value,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_DASH;
    case (value)
      5'd0: glyph = GLYPH_0;
      5'd1: glyph = GLYPH_1;
      5'd2: glyph = GLYPH_2;
      5'd3: glyph = GLYPH_3;
      5'd4: glyph = GLYPH_4;
      5'd5: glyph = GLYPH_5;
      5'd6: glyph = GLYPH_6;
      5'd7: glyph = GLYPH_7;
      5'd8: glyph = GLYPH_8;
      5'd9: glyph = GLYPH_9;
      default: glyph = GLYPH_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Multiplexed 4-digit display scanner with frame-coherent snapshot and
// adjust-mode blinking of the selected digit pair.
module seg_scan
  import seg_scan_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] min_l,
  input  logic [4:0] min_r,
  input  logic [4:0] sec_l,
  input  logic [4:0] sec_r,
  input  logic       adj_en,
  input  logic [2:0] adj_sel,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0] refresh_cnt_reg;
  logic [1:0]       idx_reg;
  logic [FRM_W-1:0] frame_cnt_reg;
  logic             blink_phase_reg;
  logic [3:0][4:0]  snap_reg;
  logic             tick;
  logic             frame_wrap;
  logic             blank_slot;
  logic [6:0]       glyph;

  assign tick       = (refresh_cnt_reg == CNT_LAST);
  assign frame_wrap = tick && (idx_reg == IDX_MIN_L);
  assign blank_slot = adj_en && blink_phase_reg && in_adj_pair(adj_sel, idx_reg);

  seg7_decode u_decode (
    .value (snap_reg[idx_reg]),
    .glyph (glyph)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt_reg <= '0;
      idx_reg         <= '0;
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
      snap_reg        <= '0;
      an              <= AN_BLANK;
      seg             <= GLYPH_BLANK;
      dp              <= 1'b1;
    end else if (tick) begin
      // The slot boundary edge always blanks, which also hides anode switching.
      refresh_cnt_reg <= '0;
      idx_reg         <= idx_reg + 2'd1;
      an              <= AN_BLANK;
      seg             <= GLYPH_BLANK;
      dp              <= 1'b1;
      if (frame_wrap) begin
        snap_reg[IDX_SEC_R] <= sec_r;
        snap_reg[IDX_SEC_L] <= sec_l;
        snap_reg[IDX_MIN_R] <= min_r;
        snap_reg[IDX_MIN_L] <= min_l;
        if (frame_cnt_reg == FRM_LAST) begin
          frame_cnt_reg   <= '0;
          blink_phase_reg <= !blink_phase_reg;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + FRM_W'(1);
        end
      end
    end else begin
      refresh_cnt_reg <= refresh_cnt_reg + CNT_W'(1);
      if (blank_slot) begin
        an  <= AN_BLANK;
        seg <= GLYPH_BLANK;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << idx_reg);
        seg <= glyph;
        dp  <= (idx_reg != IDX_MIN_R);
      end
    end
  end

endmodule
